dual_port_mem_arbiter: RTL and testbench
========================================

# dual_port_mem_arbiter

Arbitrates a single-ported 32-bit word memory between the pipeline's instruction port (read-only) and data port (read/write with byte enables). It sits between the CPU's imem/dmem interfaces and one shared memory or cache port. Ports and handshakes match the dual-port word memory, so the arbiter can be dropped in front of a single-port backend without touching the core. The data port has fixed priority, with a starvation guard that guarantees instruction-fetch progress.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction request waits; range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_read  in  1  instruction read request; held high until imem_resp.
- imem_address  in  32  instruction word address.
- imem_resp  out  1  one-cycle completion pulse.
- imem_rdata  out  32  read data, valid when imem_resp=1.
- dmem_read, dmem_write  in  1 each  data request; mutually exclusive; held until dmem_resp.
- dmem_byte_enable  in  4  write byte lanes; bit i enables wdata[8i+7:8i].
- dmem_address  in  32  data address.
- dmem_wdata  in  32  write data.
- dmem_resp  out  1  one-cycle completion pulse.
- dmem_rdata  out  32  read data, valid when dmem_resp=1.
- mem_read, mem_write  out  1 each  backend request; registered.
- mem_byte_enable  out  4  registered; 4'b1111 for reads.
- mem_address  out  32  registered.
- mem_wdata  out  32  registered.
- mem_resp  in  1  backend completion.
- mem_rdata  in  32  backend read data.

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE: arbitrate each cycle.
  - If only D is requesting, grant D.
  - If only I is requesting, grant I.
  - If both are requesting, grant D unless starve_cnt == STARVE_LIMIT, in which case grant I.
- Grant behaviour: capture the winner's address, wdata, byte_enable and direction into output registers, then enter SERVE_x.
- SERVE_x: hold mem_* constant until mem_resp=1, then return to IDLE on the next edge.
- mem_read/mem_write are high only in SERVE states. They are registered, so they are never combinational from requester inputs.
- Response routing, same cycle as mem_resp in SERVE_x:
  - x_resp = 1 and x_rdata = mem_rdata.
  - The other port's resp stays 0.
  - dmem_rdata is don't-care on writes but is still driven with mem_rdata.
- mem_resp in IDLE is ignored. The backend may emit a trailing resp because the request is still sampled high on the completion edge. Do not forward it.
- starve_cnt, 4 bits:
  - Increments on each D grant made while imem_read=1.
  - Clears on any I grant, or when IDLE sees imem_read=0.
  - Saturates at STARVE_LIMIT.
- Once granted, a transaction always completes. A request withdrawn mid-transaction (a protocol violation) still produces its resp pulse.
- dmem_read and dmem_write both high is illegal. If it occurs, the arbiter treats it as a write.

## Timing
- Reset values (async, immediate): state=IDLE, starve_cnt=0; all mem_* outputs 0; imem_resp=dmem_resp=0; rdata outputs 0.
- Sequence for a request arriving in IDLE at cycle 0:
  - Cycle 1: mem_read/mem_write is high.
  - Cycle 1+L: x_resp is high, where L ≥ 1 is the backend latency (L=1 for a registered-response memory).
  - Cycle 2+L: state returns to IDLE.
- Minimum turnaround: 3 cycles per transaction. A back-to-back request is granted on the first IDLE cycle.
- A requester must drop its request the cycle after it sees resp. If the request is still high in IDLE, it is treated as a new request.
- Reset asserted mid-transaction: abort, no resp pulse, all outputs back to reset values. After rst_n deasserts, a pending request is re-arbitrated from IDLE.
- Simultaneous mem_resp and new requests in SERVE: no new grant that cycle. Arbitration happens only in IDLE.

## Test plan
- Lone I read, addr 0x60, backend returns 0x00000013 with L=1 → mem_read high cycle 1 with mem_address=0x60 and mem_byte_enable=4'hF; imem_resp cycle 2 with imem_rdata=0x00000013; dmem_resp stays 0.
- D write, addr 0x100, wdata 0xDEADBEEF, be 4'b0101 → mem_write=1 with mem_wdata=0xDEADBEEF and mem_byte_enable=4'b0101; dmem_resp one cycle after mem_resp; the trailing mem_resp in IDLE produces no resp.
- I and D requesting together from reset → D granted first; I granted next.
- Continuous D requests plus an I request, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,...; starve_cnt returns to 0 after the I grant.
- Backend with L=5 → mem_* stable for all 5 cycles; exactly one resp pulse.
- rst_n pulled low during SERVE_D at L=3 → outputs zero immediately with no dmem_resp; after release, the held dmem request completes normally.

Source files
------------

// File: rtl/dual_port_mem_arbiter_if.sv
// Bundle of the instruction, data and backend memory ports
// around the single-port memory arbiter.
interface dual_port_mem_arbiter_if;
   logic        imem_read;
   logic [31:0] imem_address;
   logic        imem_resp;
   logic [31:0] imem_rdata;

   logic        dmem_read;
   logic        dmem_write;
   logic [3:0]  dmem_byte_enable;
   logic [31:0] dmem_address;
   logic [31:0] dmem_wdata;
   logic        dmem_resp;
   logic [31:0] dmem_rdata;

   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic        mem_resp;
   logic [31:0] mem_rdata;

   modport slave (
      input  imem_read, imem_address,
      output imem_resp, imem_rdata,
      input  dmem_read, dmem_write, dmem_byte_enable,
      input  dmem_address, dmem_wdata,
      output dmem_resp, dmem_rdata,
      output mem_read, mem_write, mem_byte_enable,
      output mem_address, mem_wdata,
      input  mem_resp, mem_rdata
   );

   modport master (
      output imem_read, imem_address,
      input  imem_resp, imem_rdata,
      output dmem_read, dmem_write, dmem_byte_enable,
      output dmem_address, dmem_wdata,
      input  dmem_resp, dmem_rdata,
      input  mem_read, mem_write, mem_byte_enable,
      input  mem_address, mem_wdata,
      output mem_resp, mem_rdata
   );
endinterface

// File: rtl/dual_port_mem_arbiter.sv
// Shares one word memory port between instruction and data ports.
// Data has priority; a starvation counter forces periodic fetches.
module dual_port_mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                     clk,
   input logic                     rst_n,
   dual_port_mem_arbiter_if.slave  bus
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D
   } state_t;

   state_t      state;
   logic [3:0]  starve_cnt;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;

   logic i_req;
   logic d_req;
   logic grant_d;
   logic grant_i;

   always_comb begin
      i_req   = bus.imem_read;
      d_req   = bus.dmem_read | bus.dmem_write;
      grant_d = d_req && (!i_req || starve_cnt != LIMIT);
      grant_i = i_req && !grant_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         starve_cnt      <= '0;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         mem_byte_enable <= '0;
         mem_address     <= '0;
         mem_wdata       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               unique case (1'b1)
                  grant_d: begin
                     // read+write together is resolved as a write
                     mem_read        <= bus.dmem_read & ~bus.dmem_write;
                     mem_write       <= bus.dmem_write;
                     mem_byte_enable <= bus.dmem_write ?
                                        bus.dmem_byte_enable : 4'hF;
                     mem_address     <= bus.dmem_address;
                     mem_wdata       <= bus.dmem_wdata;
                     state           <= SERVE_D;
                     if (i_req) begin
                        if (starve_cnt != LIMIT)
                           starve_cnt <= starve_cnt + 4'd1;
                     end else begin
                        starve_cnt <= '0;
                     end
                  end
                  grant_i: begin
                     mem_read        <= 1'b1;
                     mem_write       <= 1'b0;
                     mem_byte_enable <= 4'hF;
                     mem_address     <= bus.imem_address;
                     mem_wdata       <= '0;
                     state           <= SERVE_I;
                     starve_cnt      <= '0;
                  end
                  default: begin
                     starve_cnt <= '0;
                  end
               endcase
            end
            SERVE_I, SERVE_D: begin
               if (bus.mem_resp) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // responses are only forwarded while serving, so a trailing
   // backend resp seen in IDLE is dropped
   always_comb begin
      bus.imem_resp  = (state == SERVE_I) && bus.mem_resp;
      bus.dmem_resp  = (state == SERVE_D) && bus.mem_resp;
      bus.imem_rdata = bus.imem_resp ? bus.mem_rdata : '0;
      bus.dmem_rdata = bus.dmem_resp ? bus.mem_rdata : '0;
   end

   assign bus.mem_read        = mem_read;
   assign bus.mem_write       = mem_write;
   assign bus.mem_byte_enable = mem_byte_enable;
   assign bus.mem_address     = mem_address;
   assign bus.mem_wdata       = mem_wdata;

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// Directed bench for dual_port_mem_arbiter with a
// latency-programmable registered backend model.
module tb_dual_port_mem_arbiter;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   int          lat;
   logic [31:0] rdata_val;
   int          bcnt;

   dual_port_mem_arbiter_if bus ();

   dual_port_mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // backend: resp arrives L cycles after the request is first seen
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.mem_resp  <= 1'b0;
         bus.mem_rdata <= '0;
         bcnt          <= 0;
      end else if (bus.mem_read | bus.mem_write) begin
         if (bcnt >= lat - 1) begin
            bus.mem_resp  <= 1'b1;
            bus.mem_rdata <= rdata_val;
            bcnt          <= 0;
         end else begin
            bus.mem_resp <= 1'b0;
            bcnt         <= bcnt + 1;
         end
      end else begin
         bus.mem_resp <= 1'b0;
         bcnt         <= 0;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic       prev;
      logic       req;
      logic       done;
      logic [5:0] seq;
      int         ng;
      int         pulses;
      int         stable;
      int         rc;

      checks = 0;
      errors = 0;
      lat = 1;
      rdata_val = '0;
      rst_n = 1'b0;
      bus.imem_read = 1'b0;
      bus.imem_address = '0;
      bus.dmem_read = 1'b0;
      bus.dmem_write = 1'b0;
      bus.dmem_byte_enable = '0;
      bus.dmem_address = '0;
      bus.dmem_wdata = '0;

      cyc(2);
      chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
      chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
      chk("rst_mem_addr", bus.mem_address, 32'd0);
      chk("rst_mem_be", 32'(bus.mem_byte_enable), 32'd0);
      chk("rst_iresp", 32'(bus.imem_resp), 32'd0);
      chk("rst_drdata", bus.dmem_rdata, 32'd0);
      chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
      rst_n = 1'b1;

      // lone instruction read
      rdata_val = 32'h0000_0013;
      bus.imem_read = 1'b1;
      bus.imem_address = 32'h60;
      cyc(1);
      chk("i_mem_read", 32'(bus.mem_read), 32'd1);
      chk("i_mem_addr", bus.mem_address, 32'h60);
      chk("i_mem_be", 32'(bus.mem_byte_enable), 32'hF);
      chk("i_early_resp", 32'(bus.imem_resp), 32'd0);
      cyc(1);
      chk("i_resp", 32'(bus.imem_resp), 32'd1);
      chk("i_rdata", bus.imem_rdata, 32'h13);
      chk("i_no_dresp", 32'(bus.dmem_resp), 32'd0);
      bus.imem_read = 1'b0;
      cyc(1);
      chk("i_trail_iresp", 32'(bus.imem_resp), 32'd0);
      chk("i_idle_read", 32'(bus.mem_read), 32'd0);

      // data write with byte enables
      bus.dmem_write = 1'b1;
      bus.dmem_address = 32'h100;
      bus.dmem_wdata = 32'hDEAD_BEEF;
      bus.dmem_byte_enable = 4'b0101;
      cyc(1);
      chk("w_mem_write", 32'(bus.mem_write), 32'd1);
      chk("w_mem_read", 32'(bus.mem_read), 32'd0);
      chk("w_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("w_mem_be", 32'(bus.mem_byte_enable), 32'h5);
      chk("w_mem_addr", bus.mem_address, 32'h100);
      chk("w_early_resp", 32'(bus.dmem_resp), 32'd0);
      cyc(1);
      chk("w_resp", 32'(bus.dmem_resp), 32'd1);
      bus.dmem_write = 1'b0;
      cyc(1);
      chk("w_trail_dresp", 32'(bus.dmem_resp), 32'd0);
      chk("w_idle_write", 32'(bus.mem_write), 32'd0);

      // illegal read+write resolves as write
      bus.dmem_read = 1'b1;
      bus.dmem_write = 1'b1;
      bus.dmem_address = 32'h104;
      bus.dmem_byte_enable = 4'h3;
      cyc(1);
      chk("rw_mem_write", 32'(bus.mem_write), 32'd1);
      chk("rw_mem_read", 32'(bus.mem_read), 32'd0);
      chk("rw_mem_be", 32'(bus.mem_byte_enable), 32'h3);
      cyc(1);
      chk("rw_resp", 32'(bus.dmem_resp), 32'd1);
      bus.dmem_read = 1'b0;
      bus.dmem_write = 1'b0;
      cyc(1);

      // simultaneous requests: data first, then instruction
      rdata_val = 32'h1111_2222;
      bus.dmem_read = 1'b1;
      bus.dmem_address = 32'h200;
      bus.imem_read = 1'b1;
      bus.imem_address = 32'h60;
      cyc(1);
      chk("both_first_d", bus.mem_address, 32'h200);
      chk("both_starve1", 32'(dut.starve_cnt), 32'd1);
      cyc(1);
      chk("both_dresp", 32'(bus.dmem_resp), 32'd1);
      bus.dmem_read = 1'b0;
      cyc(2);
      chk("both_then_i", bus.mem_address, 32'h60);
      chk("both_starve0", 32'(dut.starve_cnt), 32'd0);
      cyc(1);
      chk("both_iresp", 32'(bus.imem_resp), 32'd1);
      bus.imem_read = 1'b0;
      cyc(1);

      // continuous data traffic with a waiting fetch
      bus.dmem_read = 1'b1;
      bus.dmem_address = 32'h200;
      bus.imem_read = 1'b1;
      prev = 1'b0;
      done = 1'b0;
      seq = '0;
      ng = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         cyc(1);
         req = bus.mem_read | bus.mem_write;
         if (req && !prev && ng < 6) begin
            seq[ng] = (bus.mem_address == 32'h200);
            if (ng == 3)
               chk("starve_at_4", 32'(dut.starve_cnt), 32'd4);
            if (ng == 4)
               chk("starve_clear", 32'(dut.starve_cnt), 32'd0);
            ng++;
         end
         prev = req;
         if (bus.imem_resp)
            bus.imem_read = 1'b0;
         if (bus.dmem_resp && ng == 6) begin
            bus.dmem_read = 1'b0;
            done = 1'b1;
         end
      end
      chk("starve_grants", 32'(ng), 32'd6);
      chk("starve_order", 32'(seq), 32'b10_1111);
      cyc(2);

      // long backend latency
      lat = 5;
      rdata_val = 32'hCAFE_F00D;
      bus.dmem_read = 1'b1;
      bus.dmem_address = 32'h300;
      pulses = 0;
      stable = 0;
      rc = 0;
      for (int i = 1; i <= 10; i++) begin
         cyc(1);
         if (bus.mem_read && bus.mem_address == 32'h300 &&
             bus.mem_byte_enable == 4'hF)
            stable++;
         if (bus.dmem_resp) begin
            pulses++;
            rc = i;
            chk("l5_rdata", bus.dmem_rdata, 32'hCAFE_F00D);
            bus.dmem_read = 1'b0;
         end
      end
      chk("l5_stable", 32'(stable), 32'd6);
      chk("l5_pulses", 32'(pulses), 32'd1);
      chk("l5_resp_cycle", 32'(rc), 32'd6);

      // reset in the middle of a data transaction
      lat = 3;
      rdata_val = 32'h0BAD_F00D;
      bus.dmem_read = 1'b1;
      bus.dmem_address = 32'h400;
      cyc(1);
      chk("rm_serving", 32'(bus.mem_read), 32'd1);
      cyc(1);
      rst_n = 1'b0;
      #1;
      chk("rm_read_zero", 32'(bus.mem_read), 32'd0);
      chk("rm_addr_zero", bus.mem_address, 32'd0);
      chk("rm_be_zero", 32'(bus.mem_byte_enable), 32'd0);
      chk("rm_no_dresp", 32'(bus.dmem_resp), 32'd0);
      cyc(2);
      chk("rm_hold_dresp", 32'(bus.dmem_resp), 32'd0);
      rst_n = 1'b1;
      pulses = 0;
      rc = 0;
      for (int i = 1; i <= 8; i++) begin
         cyc(1);
         if (bus.dmem_resp) begin
            pulses++;
            rc = i;
            chk("rm_rdata", bus.dmem_rdata, 32'h0BAD_F00D);
            bus.dmem_read = 1'b0;
         end
      end
      chk("rm_pulses", 32'(pulses), 32'd1);
      chk("rm_resp_cycle", 32'(rc), 32'd4);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
